// File: rtl/stim_vector_gen.sv
// Seedable, bounded stimulus vector source for the a_<i>_<j> input pairs of DUT `test`.
// First vector appears one edge after start; no backpressure, enable low only pauses the run.
`timescale 1ns/1ps
module stim_vector_gen #(
  parameter int NUM_PAIRS   = 10,
  parameter int NUM_VECTORS = 16,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                   clock,
  input  logic                   DEFAULT_RESET,
  input  logic                   enable,
  input  logic [1:0]             mode,
  input  logic [31:0]            seed,
  input  logic                   load_seed,
  output logic [2*NUM_PAIRS-1:0] a_out,
  output logic                   valid,
  output logic                   done,
  output logic [15:0]            vec_count
);

  localparam int          W         = 2 * NUM_PAIRS;
  localparam logic [31:0] TAPS      = 32'h80200003;
  localparam logic [15:0] LAST_VEC  = 16'(NUM_VECTORS);
  localparam logic [7:0]  LAST_HOLD = 8'(HOLD_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] M_LFSR   = 2'd0;
  localparam logic [1:0] M_WALK   = 2'd1;
  localparam logic [1:0] M_HOLD   = 2'd2;
  localparam logic [1:0] M_TOGGLE = 2'd3;

  logic [1:0]   state;
  logic [1:0]   mode_q;
  logic [31:0]  lfsr;
  logic [7:0]   hold_cnt;

  logic [31:0]  seed_fix;
  logic [31:0]  lfsr_base;
  logic [31:0]  lfsr_step;
  logic [1:0]   pat_mode;
  logic         pat_first;
  logic [W-1:0] pat_vec;

  // In IDLE a same-edge seed load feeds straight into the first vector.
  always_comb begin
    seed_fix  = (seed == 32'h0) ? 32'h1 : seed;
    lfsr_base = (state == S_IDLE && load_seed) ? seed_fix : lfsr;
    lfsr_step = lfsr_base[0] ? ((lfsr_base >> 1) ^ TAPS) : (lfsr_base >> 1);
    pat_first = (state == S_IDLE);
    pat_mode  = pat_first ? mode : mode_q;
    pat_vec   = a_out;
    case (pat_mode)
      M_LFSR:   pat_vec = lfsr_step[W-1:0];
      M_WALK:   pat_vec = pat_first ? {{(W-1){1'b0}}, 1'b1} : {a_out[W-2:0], a_out[W-1]};
      M_HOLD:   pat_vec = a_out;
      M_TOGGLE: pat_vec = ~a_out;
      default:  pat_vec = a_out;
    endcase
  end

  always_ff @(posedge clock) begin
    if (DEFAULT_RESET) begin
      state     <= S_IDLE;
      mode_q    <= M_LFSR;
      lfsr      <= 32'h1;
      hold_cnt  <= 8'd0;
      a_out     <= '0;
      valid     <= 1'b0;
      done      <= 1'b0;
      vec_count <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (load_seed) lfsr <= seed_fix;
          if (enable) begin
            mode_q    <= mode;
            state     <= S_RUN;
            a_out     <= pat_vec;
            valid     <= 1'b1;
            vec_count <= 16'd1;
            hold_cnt  <= 8'd0;
            if (mode == M_LFSR) lfsr <= lfsr_step;
          end
        end
        S_RUN: begin
          if (!enable) begin
            valid <= 1'b0;
          end else begin
            valid <= 1'b1;
            if (hold_cnt != LAST_HOLD) begin
              hold_cnt <= hold_cnt + 8'd1;
            end else begin
              hold_cnt <= 8'd0;
              if (vec_count == LAST_VEC) begin
                state <= S_DONE;
                valid <= 1'b0;
                done  <= 1'b1;
              end else begin
                a_out     <= pat_vec;
                vec_count <= vec_count + 16'd1;
                if (mode_q == M_LFSR) lfsr <= lfsr_step;
              end
            end
          end
        end
        S_DONE: begin
          if (load_seed) lfsr <= seed_fix;
          if (!enable) begin
            state <= S_IDLE;
            done  <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stim_vector_gen.sv
// Bench for stim_vector_gen: three instances (NV/HOLD = 4/1, 21/1, 4/3) share one stimulus stream.
`timescale 1ns/1ps
module tb_stim_vector_gen;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst, en, ld;
  logic [1:0]  md;
  logic [31:0] seed;

  logic [19:0] a_o [3];
  logic        v_o [3];
  logic        d_o [3];
  logic [15:0] c_o [3];

  stim_vector_gen #(.NUM_PAIRS(10), .NUM_VECTORS(4), .HOLD_CYCLES(1)) u0 (
    .clock(clock), .DEFAULT_RESET(rst), .enable(en), .mode(md), .seed(seed), .load_seed(ld),
    .a_out(a_o[0]), .valid(v_o[0]), .done(d_o[0]), .vec_count(c_o[0]));
  stim_vector_gen #(.NUM_PAIRS(10), .NUM_VECTORS(21), .HOLD_CYCLES(1)) u1 (
    .clock(clock), .DEFAULT_RESET(rst), .enable(en), .mode(md), .seed(seed), .load_seed(ld),
    .a_out(a_o[1]), .valid(v_o[1]), .done(d_o[1]), .vec_count(c_o[1]));
  stim_vector_gen #(.NUM_PAIRS(10), .NUM_VECTORS(4), .HOLD_CYCLES(3)) u2 (
    .clock(clock), .DEFAULT_RESET(rst), .enable(en), .mode(md), .seed(seed), .load_seed(ld),
    .a_out(a_o[2]), .valid(v_o[2]), .done(d_o[2]), .vec_count(c_o[2]));

  int nvp [3] = '{4, 21, 4};
  int hcp [3] = '{1, 1, 3};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: phase 0/1/2 = idle/running/finished; ticks = hold slots issued so far.
  int          m_ph    [3];
  int          m_ticks [3];
  logic [31:0] m_lf    [3];
  logic [19:0] m_a     [3];
  logic        m_v     [3];
  logic        m_d     [3];
  logic [1:0]  m_md    [3];

  function automatic logic [31:0] lfsr_next(input logic [31:0] x);
    return (x >> 1) ^ (x[0] ? 32'h80200003 : 32'h0);
  endfunction

  function automatic logic [19:0] pat(input logic [1:0] m, input bit first,
                                      input logic [19:0] prev, input logic [31:0] lf);
    case (m)
      2'd0:    return lf[19:0];
      2'd1:    return first ? 20'h1 : ((prev << 1) | (prev >> 19));
      2'd2:    return prev;
      default: return ~prev;
    endcase
  endfunction

  function automatic int exp_cnt(input int k);
    return (m_ticks[k] + hcp[k] - 1) / hcp[k];
  endfunction

  task automatic model_step();
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        m_ph[k] = 0; m_ticks[k] = 0; m_lf[k] = 32'h1; m_a[k] = '0;
        m_v[k] = 1'b0; m_d[k] = 1'b0; m_md[k] = 2'd0;
      end else if (m_ph[k] == 0) begin
        if (ld) m_lf[k] = (seed == 0) ? 32'h1 : seed;
        if (en) begin
          m_md[k] = md;
          if (md == 2'd0) m_lf[k] = lfsr_next(m_lf[k]);
          m_a[k] = pat(md, 1'b1, m_a[k], m_lf[k]);
          m_ticks[k] = 1; m_v[k] = 1'b1; m_ph[k] = 1;
        end
      end else if (m_ph[k] == 1) begin
        if (!en) m_v[k] = 1'b0;
        else begin
          m_v[k] = 1'b1;
          if (m_ticks[k] % hcp[k] != 0) m_ticks[k]++;
          else if (m_ticks[k] / hcp[k] == nvp[k]) begin
            m_ph[k] = 2; m_v[k] = 1'b0; m_d[k] = 1'b1;
          end else begin
            if (m_md[k] == 2'd0) m_lf[k] = lfsr_next(m_lf[k]);
            m_a[k] = pat(m_md[k], 1'b0, m_a[k], m_lf[k]);
            m_ticks[k]++;
          end
        end
      end else begin
        if (ld) m_lf[k] = (seed == 0) ? 32'h1 : seed;
        if (!en) begin m_ph[k] = 0; m_d[k] = 1'b0; end
      end
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic cyc();
    @(posedge clock);
    model_step();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; ld = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ld = 1'b1; md = 2'd3; seed = 32'h1234;
    cyc(); cyc();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (a_o[k] !== 20'h0 || v_o[k] !== 1'b0 || d_o[k] !== 1'b0 || c_o[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got a=%h v=%b d=%b c=%0d, want all zero", k, a_o[k], v_o[k], d_o[k], c_o[k]);
      end
    end
    rst = 1'b0; en = 1'b0; ld = 1'b0;
  endtask

  task automatic test_random_stream();
    logic [19:0] ev [4];
    ev = '{20'h00003, 20'h00002, 20'h80001, 20'hC0003};
    apply_reset();
    seed = 32'h1; ld = 1'b1; cyc();
    ld = 1'b0; md = 2'd0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if (a_o[0] !== ev[i] || v_o[0] !== 1'b1 || c_o[0] !== 16'(i + 1)) begin
        n_fail++;
        $display("FAIL random_stream v%0d: got a=%h v=%b c=%0d, want a=%h v=1 c=%0d", i + 1, a_o[0], v_o[0], c_o[0], ev[i], i + 1);
      end
    end
    cyc();
    n_tests++;
    if (d_o[0] !== 1'b1 || v_o[0] !== 1'b0 || c_o[0] !== 16'd4 || a_o[0] !== 20'hC0003) begin
      n_fail++;
      $display("FAIL random_done: got d=%b v=%b c=%0d a=%h, want d=1 v=0 c=4 a=c0003", d_o[0], v_o[0], c_o[0], a_o[0]);
    end
    en = 1'b0; cyc();
    n_tests++;
    if (d_o[0] !== 1'b0 || c_o[0] !== 16'd4 || a_o[0] !== 20'hC0003) begin
      n_fail++;
      $display("FAIL done_to_idle: got d=%b c=%0d a=%h, want d=0 c=4 a=c0003", d_o[0], c_o[0], a_o[0]);
    end
  endtask

  task automatic test_walking_wrap();
    logic [19:0] e;
    apply_reset();
    md = 2'd1; en = 1'b1;
    for (int i = 1; i <= 21; i++) begin
      cyc();
      e = 20'h1 << ((i - 1) % 20);
      n_tests++;
      if (a_o[1] !== e || c_o[1] !== 16'(i) || v_o[1] !== 1'b1) begin
        n_fail++;
        $display("FAIL walking v%0d: got a=%h c=%0d v=%b, want a=%h c=%0d v=1", i, a_o[1], c_o[1], v_o[1], e, i);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_hold_toggle();
    logic [19:0] e;
    apply_reset();
    md = 2'd3; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      e = (i < 3) ? 20'hFFFFF : 20'h00000;
      n_tests++;
      if (a_o[2] !== e || c_o[2] !== 16'(i / 3 + 1) || v_o[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_toggle cyc%0d: got a=%h c=%0d v=%b, want a=%h c=%0d v=1", i, a_o[2], c_o[2], v_o[2], e, i / 3 + 1);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_pause();
    int vcnt [3];
    int budget;
    vcnt = '{0, 0, 0};
    apply_reset();
    seed = 32'h1; ld = 1'b1; cyc();
    ld = 1'b0; md = 2'd0; en = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      for (int k = 0; k < 3; k++) if (v_o[k] === 1'b1) vcnt[k]++;
    end
    n_tests++;
    if (a_o[0] !== 20'h00002 || c_o[0] !== 16'd2) begin
      n_fail++;
      $display("FAIL pause_pre: got a=%h c=%0d, want a=00002 c=2", a_o[0], c_o[0]);
    end
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      for (int k = 0; k < 3; k++) if (v_o[k] === 1'b1) vcnt[k]++;
      n_tests++;
      if (v_o[0] !== 1'b0 || a_o[0] !== 20'h00002 || c_o[0] !== 16'd2) begin
        n_fail++;
        $display("FAIL pause_frozen cyc%0d: got v=%b a=%h c=%0d, want v=0 a=00002 c=2", i, v_o[0], a_o[0], c_o[0]);
      end
    end
    en = 1'b1;
    cyc();
    for (int k = 0; k < 3; k++) if (v_o[k] === 1'b1) vcnt[k]++;
    n_tests++;
    if (v_o[0] !== 1'b1 || a_o[0] !== 20'h80001 || c_o[0] !== 16'd3) begin
      n_fail++;
      $display("FAIL pause_resume: got v=%b a=%h c=%0d, want v=1 a=80001 c=3", v_o[0], a_o[0], c_o[0]);
    end
    budget = 0;
    while (!(d_o[0] === 1'b1 && d_o[1] === 1'b1 && d_o[2] === 1'b1) && budget < 100) begin
      cyc();
      budget++;
      for (int k = 0; k < 3; k++) begin
        if (v_o[k] === 1'b1) vcnt[k]++;
        n_tests++;
        if (a_o[k] !== m_a[k] || v_o[k] !== m_v[k] || d_o[k] !== m_d[k] || c_o[k] !== 16'(exp_cnt(k))) begin
          n_fail++;
          $display("FAIL pause_model[%0d]: got a=%h v=%b d=%b c=%0d, want a=%h v=%b d=%b c=%0d",
                   k, a_o[k], v_o[k], d_o[k], c_o[k], m_a[k], m_v[k], m_d[k], exp_cnt(k));
        end
      end
    end
    n_tests++;
    if (budget >= 100) begin
      n_fail++;
      $display("FAIL pause_timeout: done not reached within %0d cycles", budget);
    end
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (vcnt[k] != nvp[k] * hcp[k]) begin
        n_fail++;
        $display("FAIL pause_valid_total[%0d]: got %0d, want %0d", k, vcnt[k], nvp[k] * hcp[k]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_reset_midrun();
    int budget;
    apply_reset();
    seed = 32'h1; ld = 1'b1; cyc();
    ld = 1'b0; md = 2'd0; en = 1'b1;
    budget = 0;
    while (c_o[0] !== 16'd3 && budget < 10) begin cyc(); budget++; end
    n_tests++;
    if (c_o[0] !== 16'd3) begin
      n_fail++;
      $display("FAIL midrun_reach: got c=%0d, want 3", c_o[0]);
    end
    rst = 1'b1; cyc();
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (a_o[k] !== 20'h0 || v_o[k] !== 1'b0 || d_o[k] !== 1'b0 || c_o[k] !== 16'd0) begin
        n_fail++;
        $display("FAIL midrun_reset[%0d]: got a=%h v=%b d=%b c=%0d, want all zero", k, a_o[k], v_o[k], d_o[k], c_o[k]);
      end
    end
    rst = 1'b0;
    cyc();
    n_tests++;
    if (a_o[0] !== 20'h00003 || c_o[0] !== 16'd1) begin
      n_fail++;
      $display("FAIL midrun_restart v1: got a=%h c=%0d, want a=00003 c=1", a_o[0], c_o[0]);
    end
    cyc();
    n_tests++;
    if (a_o[0] !== 20'h00002 || c_o[0] !== 16'd2) begin
      n_fail++;
      $display("FAIL midrun_restart v2: got a=%h c=%0d, want a=00002 c=2", a_o[0], c_o[0]);
    end
    en = 1'b0;
  endtask

  task automatic test_seed_zero();
    logic [19:0] ev [4];
    ev = '{20'h00003, 20'h00002, 20'h80001, 20'hC0003};
    apply_reset();
    seed = $urandom | 32'h2; ld = 1'b1; cyc();
    seed = 32'h0; ld = 1'b1; md = 2'd0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      ld = 1'b0;
      n_tests++;
      if (a_o[0] !== ev[i]) begin
        n_fail++;
        $display("FAIL seed_zero v%0d: got %h, want %h", i + 1, a_o[0], ev[i]);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_load_in_run();
    logic [19:0] ev [4];
    ev = '{20'h00003, 20'h00002, 20'h80001, 20'hC0003};
    apply_reset();
    seed = 32'h1; ld = 1'b1; cyc();
    ld = 1'b0; md = 2'd0; en = 1'b1;
    cyc();
    ld = 1'b1; seed = $urandom | 32'h4; md = 2'd1;
    for (int i = 1; i < 4; i++) begin
      cyc();
      n_tests++;
      if (a_o[0] !== ev[i]) begin
        n_fail++;
        $display("FAIL load_in_run v%0d: got %h, want %h", i + 1, a_o[0], ev[i]);
      end
    end
    ld = 1'b0; en = 1'b0;
  endtask

  task automatic test_random();
    for (int run = 0; run < 6; run++) begin
      apply_reset();
      for (int c = 0; c < 120; c++) begin
        rst  = ($urandom_range(0, 99) < 2);
        en   = ($urandom_range(0, 99) < 80);
        ld   = ($urandom_range(0, 99) < 10);
        md   = 2'($urandom_range(0, 3));
        seed = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
        cyc();
        for (int k = 0; k < 3; k++) begin
          n_tests++;
          if (a_o[k] !== m_a[k] || v_o[k] !== m_v[k] || d_o[k] !== m_d[k] || c_o[k] !== 16'(exp_cnt(k))) begin
            n_fail++;
            $display("FAIL random_model run%0d cyc%0d [%0d]: got a=%h v=%b d=%b c=%0d, want a=%h v=%b d=%b c=%0d",
                     run, c, k, a_o[k], v_o[k], d_o[k], c_o[k], m_a[k], m_v[k], m_d[k], exp_cnt(k));
          end
        end
      end
    end
    rst = 1'b0; en = 1'b0; ld = 1'b0;
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; ld = 1'b0; md = 2'd0; seed = 32'h0;
    test_reset();
    test_random_stream();
    test_walking_wrap();
    test_hold_toggle();
    test_pause();
    test_reset_midrun();
    test_seed_zero();
    test_load_in_run();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
